disp_colr_adapt: RTL and testbench
==================================

// Module: disp_colr_adapt
// PURPOSE
//  Parametrised display colour-depth adapter between the chapter core's disp_* outputs and the
//  board video encoder (DVI/TMDS). Widens (bit replication or zero-pad) or narrows (truncate or
//  4x4 ordered dither, optionally frame-rotated) each RGB channel. Delays syncs to match.
// PARAMETERS
//  BPC_IN    5  input bits per colour channel (1..8)
//  BPC_OUT   8  output bits per colour channel (1..8)
//  MODE      0  0=replicate/truncate, 1=zero-pad/truncate, 2=ordered dither (narrowing only)
//  TEMPORAL  0  1=rotate dither matrix each frame (MODE=2 only)
// PORTS
//  clk        in   1        pixel clock
//  rst_n      in   1        asynchronous reset, active low
//  in_hsync   in   1        horizontal sync from core
//  in_vsync   in   1        vertical sync from core
//  in_de      in   1        data enable (active pixel)
//  in_frame   in   1        one-cycle start-of-frame strobe
//  in_r/g/b   in   BPC_IN   colour channels
//  out_hsync  out  1        in_hsync delayed 2 cycles
//  out_vsync  out  1        in_vsync delayed 2 cycles
//  out_de     out  1        in_de delayed 2 cycles
//  out_r/g/b  out  BPC_OUT  converted colour; 0 when out_de=0
// BEHAVIOUR
//  - rst_n low: all outputs, pipeline regs and counters 0 immediately (async); sync release.
//  - Fixed latency 2 cycles for every output. Stage 1 registers inputs and threshold;
//    stage 2 registers converted colour. No stalls, no handshake.
//  - Blanking: if stage-1 de=0, out colour = 0 regardless of input.
//  - BPC_OUT==BPC_IN: pass-through in all modes.
//  - Widening, MODE 0/2: replicate input MSB-first to fill BPC_OUT (5->8: {c,c[4:2]}).
//    MODE 1: {c, zeros}.
//  - Narrowing, MODE 0/1: top BPC_OUT bits of input.
//  - Narrowing, MODE 2: D=BPC_IN-BPC_OUT; b=Bayer4x4[yi][xi], rows {0,8,2,10},{12,4,14,6},
//    {3,11,1,9},{15,7,13,5}; thr = D<=4 ? b>>(4-D) : b<<(D-4); s=c+thr in BPC_IN+1 bits,
//    saturate to 2^BPC_IN-1; output top BPC_OUT bits of s.
//  - x counter (2b): 0 for first de cycle of a run, +1 each de cycle, wraps 3->0, cleared de=0.
//  - y counter (2b): +1 on de falling edge, wraps; cleared when in_frame=1 (frame wins over
//    simultaneous de fall).
//  - f counter (2b): +1 on each in_frame when TEMPORAL=1, else held 0; wraps.
//  - xi=(x+f) mod 4, yi=(y+f) mod 4. First frame after reset: first in_frame makes f=1.
//  - Counters sample inputs at the same edge as stage 1, so threshold aligns with its pixel.
//  - Parameter check: MODE=2 with BPC_OUT>BPC_IN behaves as MODE 0; BPC outside 1..8 is a
//    elaboration error ($error).
// TESTING
//  1 MODE0 5->8, de=1, r=5'h1F then 5'h10 -> out_r 8'hFF then 8'h84, 2 cycles later; de=0 -> 0.
//  2 Reset: drop rst_n mid-line -> all outputs 0 same cycle; release, drive de=1 r=5'h1F ->
//    out_de=1 out_r=8'hFF exactly on 2nd edge after first sampled input.
//  3 MODE1 8->5: r=8'hFF -> 5'h1F; r=8'h87 -> 5'h10; MODE1 5->8 r=5'h11 -> 8'h88.
//  4 MODE2 8->5 line 0 after in_frame, r=8'h84 for 4 px -> 10,11,10,11 (hex); r=8'hFE ->
//    saturates, 5'h1F every pixel.
//  5 MODE2 line 1, r=8'h84 -> 11,10,11,10; 5th pixel repeats 1st; in_frame coinciding with
//    de fall -> next line uses row 0.
//  6 TEMPORAL=1: second frame (f=1) line0 px0 r=8'h86 -> 5'h11 (TEMPORAL=0 gives 5'h10);
//    after 4 more frames f wraps and pattern repeats.

Source files
------------

// File: rtl/disp_colr_adapt_if.sv
// Video bus between the core's disp_* outputs and the display colour adapter.
// Stream semantics: there is no valid/ready handshake. Every clock carries one
// pixel slot; in_de marks active pixels. The adapter never stalls, and each
// out_* signal is the matching in_* signal delayed exactly two clocks.
interface disp_colr_adapt_if #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
);
    logic               in_hsync;
    logic               in_vsync;
    logic               in_de;
    logic               in_frame;
    logic [BPC_IN-1:0]  in_r;
    logic [BPC_IN-1:0]  in_g;
    logic [BPC_IN-1:0]  in_b;
    logic               out_hsync;
    logic               out_vsync;
    logic               out_de;
    logic [BPC_OUT-1:0] out_r;
    logic [BPC_OUT-1:0] out_g;
    logic [BPC_OUT-1:0] out_b;

    // Source side: drives the core pixels and receives the converted pixels.
    modport master (
        output in_hsync, in_vsync, in_de, in_frame, in_r, in_g, in_b,
        input  out_hsync, out_vsync, out_de, out_r, out_g, out_b
    );

    // Adapter side.
    modport slave (
        input  in_hsync, in_vsync, in_de, in_frame, in_r, in_g, in_b,
        output out_hsync, out_vsync, out_de, out_r, out_g, out_b
    );
endinterface

// File: rtl/disp_colr_adapt.sv
// Display colour-depth adapter: widens by replication or zero-pad, narrows by
// truncation or 4x4 ordered dither (optionally rotated every frame). Two-stage
// pipeline: stage 1 registers the pixel and its dither threshold, stage 2
// registers the converted colour. Syncs and de follow with the same latency.
module disp_colr_adapt #(
    parameter int BPC_IN   = 5,
    parameter int BPC_OUT  = 8,
    parameter int MODE     = 0,
    parameter int TEMPORAL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    disp_colr_adapt_if.slave   vid
);

    localparam bit NARROW = (BPC_OUT < BPC_IN);
    // Dither only makes sense when bits are dropped; MODE 2 otherwise acts as MODE 0.
    localparam bit DITHER = (MODE == 2) && NARROW;
    localparam bit ZPAD   = (MODE == 1);
    localparam int D      = NARROW ? (BPC_IN - BPC_OUT) : 0;
    localparam int SH_R   = (D <= 4) ? (4 - D) : 0;
    localparam int SH_L   = (D > 4) ? (D - 4) : 0;

    generate
        if (BPC_IN < 1 || BPC_IN > 8 || BPC_OUT < 1 || BPC_OUT > 8) begin : g_bad_bpc
            $error("disp_colr_adapt: BPC_IN and BPC_OUT must be in 1..8");
        end
    endgenerate

    // 4x4 Bayer matrix, row index first.
    function automatic logic [3:0] bayer(input logic [1:0] yi, input logic [1:0] xi);
        logic [3:0] b;
        case ({yi, xi})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    logic [1:0]        x_cnt;
    logic [1:0]        y_cnt;
    logic [1:0]        f_cnt;
    logic              prev_de;
    logic [1:0]        xi;
    logic [1:0]        yi;
    logic [BPC_IN:0]   thr_next;

    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_de;
    logic [BPC_IN:0]   s1_thr;
    logic [2:0][BPC_IN-1:0]  s1_c;
    logic [2:0][BPC_OUT-1:0] conv;

    // Pixel position counters; x_cnt/y_cnt already hold the position of the
    // pixel presented at this edge, so the threshold lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= 2'd0;
            y_cnt   <= 2'd0;
            f_cnt   <= 2'd0;
            prev_de <= 1'b0;
        end else begin
            prev_de <= vid.in_de;
            x_cnt   <= vid.in_de ? x_cnt + 2'd1 : 2'd0;
            if (vid.in_frame)
                y_cnt <= 2'd0;
            else if (prev_de && !vid.in_de)
                y_cnt <= y_cnt + 2'd1;
            if (TEMPORAL == 1 && vid.in_frame)
                f_cnt <= f_cnt + 2'd1;
        end
    end

    // Scale the 4-bit Bayer entry to the number of dropped bits.
    always_comb begin
        xi       = x_cnt + f_cnt;
        yi       = y_cnt + f_cnt;
        thr_next = (BPC_IN+1)'((16'(bayer(yi, xi)) >> SH_R) << SH_L)
                   & {(BPC_IN+1){DITHER}};
    end

    // Stage 1: capture syncs, colour and threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_thr   <= '0;
            s1_c     <= '0;
        end else begin
            s1_hsync <= vid.in_hsync;
            s1_vsync <= vid.in_vsync;
            s1_de    <= vid.in_de;
            s1_thr   <= thr_next;
            s1_c[0]  <= vid.in_r;
            s1_c[1]  <= vid.in_g;
            s1_c[2]  <= vid.in_b;
        end
    end

    // Per-channel conversion. The saturating add is a no-op when the threshold is zero.
    generate
        for (genvar ch = 0; ch < 3; ch++) begin : g_ch
            logic [BPC_IN:0]   sum;
            logic [BPC_IN-1:0] sat;
            assign sum = {1'b0, s1_c[ch]} + s1_thr;
            assign sat = sum[BPC_IN] ? {BPC_IN{1'b1}} : sum[BPC_IN-1:0];
            if (BPC_OUT <= BPC_IN) begin : g_narrow
                assign conv[ch] = sat[BPC_IN-1 -: BPC_OUT];
            end else if (ZPAD) begin : g_zpad
                assign conv[ch] = {sat, {(BPC_OUT-BPC_IN){1'b0}}};
            end else begin : g_repl
                for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
                    assign conv[ch][BPC_OUT-1-i] = sat[BPC_IN-1-(i % BPC_IN)];
                end
            end
        end
    endgenerate

    // Stage 2: register converted colour, blanked outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.out_hsync <= 1'b0;
            vid.out_vsync <= 1'b0;
            vid.out_de    <= 1'b0;
            vid.out_r     <= '0;
            vid.out_g     <= '0;
            vid.out_b     <= '0;
        end else begin
            vid.out_hsync <= s1_hsync;
            vid.out_vsync <= s1_vsync;
            vid.out_de    <= s1_de;
            vid.out_r     <= s1_de ? conv[0] : '0;
            vid.out_g     <= s1_de ? conv[1] : '0;
            vid.out_b     <= s1_de ? conv[2] : '0;
        end
    end

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Directed bench for disp_colr_adapt: five configurations share one stimulus
// stream; each step names the hand-computed output of the pixel it drives,
// which is compared one step later (two clock edges after sampling).
module tb_disp_colr_adapt;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // a: MODE0 5->8, b: MODE1 8->5, c: MODE1 5->8, d: MODE2 8->5, e: MODE2 8->5 temporal
    disp_colr_adapt_if #(.BPC_IN(5), .BPC_OUT(8)) if_a ();
    disp_colr_adapt_if #(.BPC_IN(8), .BPC_OUT(5)) if_b ();
    disp_colr_adapt_if #(.BPC_IN(5), .BPC_OUT(8)) if_c ();
    disp_colr_adapt_if #(.BPC_IN(8), .BPC_OUT(5)) if_d ();
    disp_colr_adapt_if #(.BPC_IN(8), .BPC_OUT(5)) if_e ();

    disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .MODE(0), .TEMPORAL(0)) u_a (.clk(clk), .rst_n(rst_n), .vid(if_a));
    disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(1), .TEMPORAL(0)) u_b (.clk(clk), .rst_n(rst_n), .vid(if_b));
    disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .MODE(1), .TEMPORAL(0)) u_c (.clk(clk), .rst_n(rst_n), .vid(if_c));
    disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(2), .TEMPORAL(0)) u_d (.clk(clk), .rst_n(rst_n), .vid(if_d));
    disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(2), .TEMPORAL(1)) u_e (.clk(clk), .rst_n(rst_n), .vid(if_e));

    typedef struct {
        logic [4:0] en;
        logic       de;
        logic       fr;
        logic [7:0] a;
        logic [4:0] b;
        logic [7:0] c;
        logic [4:0] d;
        logic [4:0] e;
    } exp_t;

    exp_t       prev;
    logic [4:0] tmp_tbl [5];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    `define DRV(IFN, V) \
        IFN.in_hsync = !de; IFN.in_vsync = fr; IFN.in_de = de; IFN.in_frame = fr; \
        IFN.in_r = V; IFN.in_g = V; IFN.in_b = V;

    task automatic drive(input logic de, input logic fr, input logic [4:0] r5, input logic [7:0] r8);
        `DRV(if_a, r5)
        `DRV(if_b, r8)
        `DRV(if_c, r5)
        `DRV(if_d, r8)
        `DRV(if_e, r8)
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one pixel slot, clock it, then check the slot driven one step earlier.
    task automatic px(input logic de, input logic fr, input logic [4:0] r5, input logic [7:0] r8,
                      input logic [4:0] en, input logic [7:0] ea, input logic [4:0] eb,
                      input logic [7:0] ec, input logic [4:0] ed, input logic [4:0] ee);
        drive(de, fr, r5, r8);
        @(posedge clk);
        #1;
        if (prev.en != 5'd0) begin
            chk("de",    {7'd0, if_d.out_de},    {7'd0, prev.de});
            chk("hsync", {7'd0, if_d.out_hsync}, {7'd0, !prev.de});
            chk("vsync", {7'd0, if_d.out_vsync}, {7'd0, prev.fr});
        end
        if (prev.en[0]) begin
            chk("a_r", if_a.out_r, prev.a);
            chk("a_g", if_a.out_g, prev.a);
            chk("a_b", if_a.out_b, prev.a);
        end
        if (prev.en[1]) chk("b_r", {3'd0, if_b.out_r}, {3'd0, prev.b});
        if (prev.en[2]) chk("c_r", if_c.out_r, prev.c);
        if (prev.en[3]) chk("d_r", {3'd0, if_d.out_r}, {3'd0, prev.d});
        if (prev.en[4]) chk("e_r", {3'd0, if_e.out_r}, {3'd0, prev.e});
        prev = '{en, de, fr, ea, eb, ec, ed, ee};
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev.en = 5'd0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        prev    = '{5'd0, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0, 5'd0, 5'd0};
        tmp_tbl = '{5'h11, 5'h10, 5'h11, 5'h10, 5'h11};
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_de",    {7'd0, if_a.out_de},    8'd0);
        chk("reset_hsync", {7'd0, if_a.out_hsync}, 8'd0);
        chk("reset_a_r",   if_a.out_r,             8'd0);
        chk("reset_d_r",   {3'd0, if_d.out_r},     8'd0);
        rst_n = 1'b1;

        // Widen (replicate / zero-pad) and truncate, then blanking.
        px(1, 0, 5'h1F, 8'hFF, 5'b00111, 8'hFF, 5'h1F, 8'hF8, 5'h0, 5'h0);
        px(1, 0, 5'h10, 8'h87, 5'b00111, 8'h84, 5'h10, 8'h80, 5'h0, 5'h0);
        px(1, 0, 5'h11, 8'h00, 5'b00111, 8'h8C, 5'h00, 8'h88, 5'h0, 5'h0);
        px(0, 0, 5'h1F, 8'hFF, 5'b00111, 8'h00, 5'h00, 8'h00, 5'h0, 5'h0);
        px(0, 0, 5'h00, 8'h00, 5'b00000, 8'h00, 5'h00, 8'h00, 5'h0, 5'h0);

        // Reset asserted mid-line clears outputs without a clock edge.
        px(1, 0, 5'h1F, 8'hFF, 5'b00001, 8'hFF, 5'h0, 8'h0, 5'h0, 5'h0);
        px(1, 0, 5'h1F, 8'hFF, 5'b00001, 8'hFF, 5'h0, 8'h0, 5'h0, 5'h0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_de",  {7'd0, if_a.out_de}, 8'd0);
        chk("async_rst_a_r", if_a.out_r,          8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev.en = 5'd0;
        px(1, 0, 5'h1F, 8'hFF, 5'b00001, 8'hFF, 5'h0, 8'h0, 5'h0, 5'h0);
        chk("rst_first_edge_de", {7'd0, if_a.out_de}, 8'd0);
        px(0, 0, 5'h00, 8'h00, 5'b00001, 8'h00, 5'h0, 8'h0, 5'h0, 5'h0);
        px(0, 0, 5'h00, 8'h00, 5'b00000, 8'h00, 5'h0, 8'h0, 5'h0, 5'h0);

        // Ordered dither, line 0 then line 1, then frame strobe on de fall.
        do_reset();
        px(0, 1, 5'h0, 8'h00, 5'b00000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h10, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h10, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        for (int i = 0; i < 4; i++)
            px(1, 0, 5'h0, 8'hFE, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h1F, 5'h0);
        px(0, 0, 5'h0, 8'h00, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h10, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h10, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        px(0, 1, 5'h0, 8'h00, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h10, 5'h0);
        px(1, 0, 5'h0, 8'h84, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h11, 5'h0);
        px(0, 0, 5'h0, 8'h00, 5'b01000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);
        px(0, 0, 5'h0, 8'h00, 5'b00000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);

        // Temporal rotation: f = 1,2,3,0,1 across five frames after reset.
        do_reset();
        px(0, 1, 5'h0, 8'h00, 5'b00000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h0);
        for (int k = 0; k < 5; k++) begin
            px(1, 0, 5'h0, 8'h86, 5'b11000, 8'h0, 5'h0, 8'h0, 5'h10, tmp_tbl[k]);
            px(0, 0, 5'h0, 8'h00, 5'b11000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h00);
            px(0, 1, 5'h0, 8'h00, 5'b00000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h00);
        end
        px(0, 0, 5'h0, 8'h00, 5'b00000, 8'h0, 5'h0, 8'h0, 5'h00, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
